// File: rtl/lsu_hs.sv
// Load/store unit: effective-address generation, byte-lane steering, and a
// request/grant/response memory handshake with load-data extension and watchdog.
module lsu_hs #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [WIDTH-1:0]  req_base,
  input  logic [15:0]       req_offset,
  input  logic [WIDTH-1:0]  req_wdata,
  input  logic [4:0]        req_rd,
  input  logic              req_gof,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_rvalid,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_gof,
  output logic [WIDTH-1:0]  wb_data,
  output logic              stall,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic               mem_we_q, mem_we_d;
  logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [4:0]         rd_q, rd_d;
  logic               gof_q, gof_d;
  logic [1:0]         size_q, size_d;
  logic               signed_q, signed_d;
  logic [1:0]         lane_q, lane_d;
  logic               wb_valid_q, wb_valid_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic               wb_gof_q, wb_gof_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;
  logic               misalign_q, misalign_d;
  logic               timeout_q, timeout_d;

  logic [ADDR_W-1:0]  ea_c;
  logic [1:0]         lane_c;
  logic               aligned_c;
  logic [3:0]         be_c;
  logic [WIDTH-1:0]   rshift_c;
  logic [WIDTH-1:0]   ld_data_c;
  logic               timeout_hit_c;

  // Effective address, alignment check and byte enables of the incoming request
  always_comb begin
    ea_c      = ADDR_W'(req_base) + {{(ADDR_W-16){req_offset[15]}}, req_offset};
    lane_c    = ea_c[1:0];
    aligned_c = 1'b0;
    be_c      = 4'b0000;
    case (req_size)
      2'd0: begin aligned_c = 1'b1;              be_c = 4'b0001 << lane_c; end
      2'd1: begin aligned_c = ~ea_c[0];          be_c = 4'b0011 << lane_c; end
      2'd2: begin aligned_c = (lane_c == 2'd0);  be_c = 4'b1111;           end
      default: begin aligned_c = 1'b0;           be_c = 4'b0000;           end
    endcase
  end

  // Lane select and zero/sign extension of the returned load word
  always_comb begin
    rshift_c  = mem_rdata >> {lane_q, 3'b000};
    ld_data_c = mem_rdata;
    case (size_q)
      2'd0: ld_data_c = signed_q ? {{(WIDTH-8){rshift_c[7]}}, rshift_c[7:0]}
                                 : {{(WIDTH-8){1'b0}}, rshift_c[7:0]};
      2'd1: ld_data_c = signed_q ? {{(WIDTH-16){rshift_c[15]}}, rshift_c[15:0]}
                                 : {{(WIDTH-16){1'b0}}, rshift_c[15:0]};
      default: ld_data_c = mem_rdata;
    endcase
  end

  // Watchdog fires on the last permitted cycle in REQ/WAIT; TIMEOUT of 0 disables it
  assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = rd_q;
    gof_d       = gof_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_gof_d    = wb_gof_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (aligned_c) begin
            mem_addr_d  = {ea_c[ADDR_W-1:2], 2'b00};
            mem_be_d    = be_c;
            mem_we_d    = req_store;
            mem_wdata_d = req_wdata << {lane_c, 3'b000};
            rd_d        = req_rd;
            gof_d       = req_gof;
            size_d      = req_size;
            signed_d    = req_signed;
            lane_d      = lane_c;
            cnt_d       = '0;
            state_d     = S_REQ;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = mem_we_q ? S_DONE : S_WAIT;
        end else if (timeout_hit_c) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_gof_d   = gof_q;
          wb_data_d  = ld_data_c;
          state_d    = S_DONE;
        end else if (timeout_hit_c) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_q        <= '0;
      gof_q       <= 1'b0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      lane_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_gof_q    <= 1'b0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
      gof_q       <= gof_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_gof_q    <= wb_gof_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign mem_req      = (state_q == S_REQ);
  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_gof       = wb_gof_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;
  // Holds the PC from the accept cycle; low in DONE so the core advances there
  assign stall = (state_q == S_REQ) | (state_q == S_WAIT) |
                 ((state_q == S_IDLE) & req_valid & aligned_c);

endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs with a writeback scoreboard.
module tb_lsu_hs;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_store, req_signed, req_gof;
  logic [1:0]  req_size;
  logic [31:0] req_base, req_wdata;
  logic [15:0] req_offset;
  logic [4:0]  req_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, wb_gof, stall, misalign_err, timeout_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct {
    logic [4:0]  rd;
    logic        gof;
    logic [31:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  lsu_hs #(.WIDTH(32), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
    .req_gof(req_gof),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_gof(wb_gof), .wb_data(wb_data),
    .stall(stall), .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] base, input logic [15:0] off,
                       input logic [31:0] wd, input logic [4:0] rd, input logic gof);
    req_valid  = 1'b1;
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
    req_rd     = rd;
    req_gof    = gof;
  endtask

  // Full aligned access; the core holds req_valid until stall falls
  task automatic access(input string nm, input logic st, input logic [1:0] sz,
                        input logic sg, input logic [31:0] base, input logic [15:0] off,
                        input logic [31:0] wd, input logic [4:0] rd, input logic gof,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input logic [31:0] exp_wb);
    wb_t got;
    drive(st, sz, sg, base, off, wd, rd, gof);
    if (!st) sb_q.push_back('{rd: rd, gof: gof, data: exp_wb});
    #1;
    chk({nm, "_stall_accept"}, 32'(stall), 32'(1));
    tick();
    for (int i = 0; i <= gnt_dly; i++) begin
      chk({nm, "_mem_req"}, 32'(mem_req), 32'(1));
      chk({nm, "_mem_addr"}, mem_addr, exp_addr);
      chk({nm, "_mem_be"}, 32'(mem_be), 32'(exp_be));
      chk({nm, "_mem_we"}, 32'(mem_we), 32'(st));
      chk({nm, "_mem_wdata"}, mem_wdata, exp_wdata);
      chk({nm, "_stall_req"}, 32'(stall), 32'(1));
      if (i == gnt_dly) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    if (!st) begin
      for (int i = 0; i <= rv_dly; i++) begin
        chk({nm, "_mem_req_wait"}, 32'(mem_req), 32'(0));
        chk({nm, "_stall_wait"}, 32'(stall), 32'(1));
        if (i == rv_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata;
        end
        tick();
      end
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    chk({nm, "_wb_valid_done"}, 32'(wb_valid), 32'(!st));
    chk({nm, "_stall_done"}, 32'(stall), 32'(0));
    chk({nm, "_ready_done"}, 32'(req_ready), 32'(0));
    if (wb_valid) begin
      if (sb_q.size() == 0) begin
        chk({nm, "_sb_underflow"}, 32'(1), 32'(0));
      end else begin
        got = sb_q.pop_front();
        chk({nm, "_wb_rd"}, 32'(wb_rd), 32'(got.rd));
        chk({nm, "_wb_gof"}, 32'(wb_gof), 32'(got.gof));
        chk({nm, "_wb_data"}, wb_data, got.data);
      end
    end
    req_valid = 1'b0;
    tick();
    chk({nm, "_wb_valid_pulse"}, 32'(wb_valid), 32'(0));
    chk({nm, "_ready_idle"}, 32'(req_ready), 32'(1));
    chk({nm, "_mem_req_idle"}, 32'(mem_req), 32'(0));
  endtask

  task automatic misalign(input string nm, input logic [1:0] sz,
                          input logic [31:0] base, input logic [15:0] off);
    drive(1'b0, sz, 1'b0, base, off, 32'h0, 5'd1, 1'b0);
    #1;
    chk({nm, "_stall"}, 32'(stall), 32'(0));
    tick();
    req_valid = 1'b0;
    chk({nm, "_err"}, 32'(misalign_err), 32'(1));
    chk({nm, "_mem_req"}, 32'(mem_req), 32'(0));
    chk({nm, "_ready"}, 32'(req_ready), 32'(1));
    tick();
    chk({nm, "_err_pulse"}, 32'(misalign_err), 32'(0));
    chk({nm, "_mem_req2"}, 32'(mem_req), 32'(0));
    chk({nm, "_wb_valid"}, 32'(wb_valid), 32'(0));
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_base = '0; req_offset = '0; req_wdata = '0; req_rd = '0; req_gof = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_mem_req", 32'(mem_req), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_wb_valid", 32'(wb_valid), 32'(0));
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_errs", 32'({misalign_err, timeout_err}), 32'(0));
    rstn = 1'b1;
    tick();

    access("word_ld", 1'b0, 2'd2, 1'b1, 32'h100, 16'h0004, 32'h0, 5'd5, 1'b0,
           32'h104, 4'b1111, 32'h0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF);
    access("sbyte_ld", 1'b0, 2'd0, 1'b1, 32'h203, 16'h0000, 32'h11, 5'd6, 1'b0,
           32'h200, 4'b1000, 32'h11000000, 0, 0, 32'h80FF1234, 32'hFFFFFF80);
    access("ubyte_ld", 1'b0, 2'd0, 1'b0, 32'h203, 16'h0000, 32'h11, 5'd7, 1'b1,
           32'h200, 4'b1000, 32'h11000000, 1, 2, 32'h80FF1234, 32'h00000080);
    access("half_st", 1'b1, 2'd1, 1'b0, 32'h10, 16'hFFFE, 32'h0000ABCD, 5'd9, 1'b0,
           32'h0C, 4'b1100, 32'hABCD0000, 3, 0, 32'h0, 32'h0);

    misalign("mis_word", 2'd2, 32'h100, 16'h0002);
    access("shalf_ld", 1'b0, 2'd1, 1'b1, 32'h100, 16'h0002, 32'h0, 5'd10, 1'b1,
           32'h100, 4'b1100, 32'h0, 0, 0, 32'h80017FFF, 32'hFFFF8001);
    misalign("mis_size3", 2'd3, 32'h100, 16'h0000);
    misalign("mis_half", 2'd1, 32'h101, 16'h0000);
    access("pos_half_ld", 1'b0, 2'd1, 1'b1, 32'h40, 16'h0000, 32'h0, 5'd11, 1'b0,
           32'h40, 4'b0011, 32'h0, 0, 0, 32'h80017FFF, 32'h00007FFF);
    access("wrap_ld", 1'b0, 2'd0, 1'b0, 32'hFFFFFFFC, 16'h0009, 32'hCC, 5'd12, 1'b0,
           32'h4, 4'b0010, 32'h0000CC00, 0, 0, 32'h123456AB, 32'h00000056);
    access("byte_st", 1'b1, 2'd0, 1'b0, 32'h300, 16'hFFFF, 32'h12345678, 5'd13, 1'b0,
           32'h2FC, 4'b1000, 32'h78000000, 0, 0, 32'h0, 32'h0);

    // Watchdog in WAIT: granted load, response never returns
    drive(1'b0, 2'd2, 1'b0, 32'h500, 16'h0000, 32'h0, 5'd14, 1'b0);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_quiet", 32'(timeout_err), 32'(0));
      tick();
    end
    chk("to_wait_err", 32'(timeout_err), 32'(1));
    chk("to_wait_wb", 32'(wb_valid), 32'(0));
    chk("to_wait_ready", 32'(req_ready), 32'(1));
    tick();
    chk("to_wait_pulse", 32'(timeout_err), 32'(0));

    // Watchdog in REQ: grant never arrives
    drive(1'b1, 2'd2, 1'b0, 32'h600, 16'h0000, 32'h1, 5'd15, 1'b0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_req_mem_req", 32'(mem_req), 32'(1));
      tick();
    end
    chk("to_req_err", 32'(timeout_err), 32'(1));
    chk("to_req_mem_req_drop", 32'(mem_req), 32'(0));
    tick();

    // Reset while waiting for a load response
    drive(1'b0, 2'd2, 1'b0, 32'h700, 16'h0000, 32'h0, 5'd16, 1'b1);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    req_valid = 1'b0;
    chk("rstw_stall_pre", 32'(stall), 32'(1));
    #2 rstn = 1'b0;
    #1;
    chk("rstw_ready", 32'(req_ready), 32'(1));
    chk("rstw_mem_addr", mem_addr, 32'h0);
    chk("rstw_wb_data", wb_data, 32'h0);
    chk("rstw_stall", 32'(stall), 32'(0));
    tick();
    rstn = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    chk("rstw_late_rvalid_wb", 32'(wb_valid), 32'(0));
    chk("rstw_late_ready", 32'(req_ready), 32'(1));
    tick();
    chk("rstw_wb_after", 32'(wb_valid), 32'(0));

    chk("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_hs.md
Name: lsu_hs

Overview:
- Parametrised load/store unit for the next-generation core; replaces the single-cycle, word-only, zero-latency data-memory path.
- Accepts one load/store request per instruction from the core datapath and computes the effective address.
- Drives a variable-latency request/grant/response memory interface with byte enables, then returns extended load data for register writeback.
- Stalls the PC/LR update while an access is in flight and flags misaligned accesses and timeouts.

Parameters:
- WIDTH, 32, data/register width; must be 32 (lane logic fixed at 4 bytes).
- ADDR_W, 32, byte-address width.
- TIMEOUT, 64, max cycles in REQ or WAIT before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a load/store this cycle
- req_ready  out  1  unit can accept a request (IDLE)
- req_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as misaligned
- req_signed  in  1  sign-extend load data (byte/half)
- req_base  in  WIDTH  base register value
- req_offset  in  16  immediate offset, sign-extended
- req_wdata  in  WIDTH  store data, right-aligned
- req_rd  in  5  destination register number
- req_gof  in  1  destination bank select (0 GPR, 1 FPR)
- mem_req  out  1  memory request valid
- mem_gnt  in  1  memory accepted request
- mem_addr  out  ADDR_W  word-aligned byte address (low 2 bits 0)
- mem_we  out  1  write strobe, qualified by mem_req
- mem_be  out  4  byte enables
- mem_wdata  out  WIDTH  lane-shifted store data
- mem_rvalid  in  1  load response valid
- mem_rdata  in  WIDTH  load response word
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  5  writeback register number
- wb_gof  out  1  writeback bank
- wb_data  out  WIDTH  extended load result
- stall  out  1  hold PC/LR/register writes
- misalign_err  out  1  one-cycle pulse
- timeout_err  out  1  one-cycle pulse

Behaviour:
- Reset (async, rstn=0): state IDLE; timeout counter cleared; every output 0 except req_ready=1. mem_req drops immediately. Reset mid-access abandons it with no writeback; a late mem_rvalid arriving in IDLE is ignored.
- Effective address: ea = req_base + sext(req_offset), truncated to ADDR_W (wraps). mem_addr = {ea[ADDR_W-1:2],2'b00}.
- Alignment: half requires ea[0]=0; word requires ea[1:0]=0; size 3 is always misaligned.
- mem_be: byte = 1<<ea[1:0]; half = 4'b0011<<ea[1:0]; word = 4'b1111.
- mem_wdata: req_wdata << 8*ea[1:0].
- IDLE: req_ready=1.
  - req_valid with misaligned address: misalign_err=1 next cycle, no memory access, no writeback, stay IDLE.
  - req_valid with aligned address: register mem_addr/be/we/wdata/rd/gof/size/signed/lane and go to REQ.
- REQ: mem_req=1; mem_addr/be/we/wdata held stable until mem_gnt.
  - mem_gnt=1: store goes to DONE; load goes to WAIT.
  - A same-cycle mem_rvalid is not sampled in REQ.
- WAIT: on mem_rvalid, select the lane by the latched ea[1:0] and size, zero- or sign-extend per req_signed (word unchanged), register into wb_data, go to DONE.
- DONE (one cycle): req_ready=0. wb_valid=1 for loads only, with wb_rd/wb_gof/wb_data. Then IDLE.
- Timeout: counter clears on entering REQ or WAIT and increments each cycle in those states. When TIMEOUT≠0 and the counter reaches TIMEOUT without gnt/rvalid: timeout_err=1 one cycle, mem_req=0, go to IDLE, no writeback.
- stall = (state==REQ) | (state==WAIT) | (state==IDLE & req_valid & aligned). Combinational, so the PC holds from the accept cycle; it is low in DONE, which is the edge at which the core advances.
- The core holds req_valid and payload until stall falls. Re-accept of the same instruction is prevented because DONE has req_ready=0.
- Latency with zero-wait memory (gnt in first REQ cycle, rvalid the next cycle): load accept→wb_valid = 3 cycles; store accept→DONE = 2 cycles.
- wb_* outputs other than wb_valid hold their last value.

Test Plan:
- Word load: base=0x100, offset=0x0004, gnt immediate, rvalid after 2 cycles with 0xDEADBEEF → mem_addr=0x104, be=1111, we=0; wb_valid one cycle with wb_data=0xDEADBEEF; stall high from accept through WAIT.
- Signed byte load: base=0x203, offset=0, rdata=0x80FF1234 → be=1000, wb_data=0xFFFFFF80. With req_signed=0 → wb_data=0x00000080.
- Half store: base=0x10, offset=0xFFFE (ea=0x0E), wdata=0x0000ABCD, gnt delayed 3 cycles → mem_addr=0x0C, be=1100, wdata=0xABCD0000, mem_req stable for 4 cycles, no wb_valid.
- Misaligned word load at ea=0x102 → misalign_err pulse, mem_req never asserted, stall low; next aligned request accepted immediately.
- Timeout: TIMEOUT=8, load granted, rvalid never returns → timeout_err exactly 8 cycles after entering WAIT, back to IDLE, no wb_valid.
- Reset asserted in WAIT, then rvalid=1 after release → outputs zeroed asynchronously, no wb_valid, req_ready=1.
